// File: rtl/kronos_mem_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch and load/store.
// Data wins by default; a saturating burst counter guarantees fetch forward progress.
module kronos_mem_arbiter #(
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic [31:0] instr_data,
  output logic        instr_ack,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic [31:0] data_rdata,
  output logic        data_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  output logic        mem_wr_en,
  output logic        mem_req,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  bus_owner
);

  localparam int unsigned CNT_NEED = $clog2(MAX_DATA_BURST + 1);
  localparam int unsigned CNT_W    = (CNT_NEED < 3) ? 3 : ((CNT_NEED > 8) ? 8 : CNT_NEED);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_DATA_BURST);
  // With no limit configured the counter only needs to avoid wrapping.
  localparam logic [CNT_W-1:0] CNT_SAT   = (MAX_DATA_BURST == 0) ? '1 : CNT_LIMIT;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_INSTR = 2'b01,
    S_DATA  = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] burst_cnt;
  logic             starve;
  logic             grant_data;
  logic             grant_instr;

  assign starve      = (MAX_DATA_BURST != 0) && instr_req && (burst_cnt == CNT_LIMIT);
  assign grant_data  = (state == S_IDLE) && data_req && !starve;
  assign grant_instr = (state == S_IDLE) && instr_req && !grant_data;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (grant_data)       state_nxt = S_DATA;
        else if (grant_instr) state_nxt = S_INSTR;
      end
      S_INSTR, S_DATA: begin
        if (mem_ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state == S_INSTR) || (state == S_DATA);
    instr_ack = mem_ack && (state == S_INSTR) && instr_req;
    data_ack  = mem_ack && (state == S_DATA) && data_req;
    bus_owner = state;
  end

  assign instr_data = mem_rdata;
  assign data_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_mask  <= '0;
      mem_wr_en <= 1'b0;
    end else if (grant_data) begin
      mem_addr  <= data_addr;
      mem_wdata <= data_wdata;
      mem_mask  <= data_mask;
      mem_wr_en <= data_wr_en;
    end else if (grant_instr) begin
      mem_addr  <= instr_addr;
      mem_wdata <= '0;
      mem_mask  <= '1;
      mem_wr_en <= 1'b0;
    end
  end

  // Counts data grants that overtook a waiting fetch; idle cycles without a fetch forgive the debt.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (grant_instr || !instr_req)
        burst_cnt <= '0;
      else if (grant_data && burst_cnt != CNT_SAT)
        burst_cnt <= burst_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Directed self-checking bench for kronos_mem_arbiter with hand-computed expectations.
module tb_kronos_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_addr;
  logic        instr_req;
  logic [31:0] instr_data;
  logic        instr_ack;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_mask;
  logic        data_wr_en;
  logic        data_req;
  logic [31:0] data_rdata;
  logic        data_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_wr_en;
  logic        mem_req;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [1:0]  bus_owner;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  kronos_mem_arbiter #(.MAX_DATA_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_addr (instr_addr),
    .instr_req  (instr_req),
    .instr_data (instr_data),
    .instr_ack  (instr_ack),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_mask  (data_mask),
    .data_wr_en (data_wr_en),
    .data_req   (data_req),
    .data_rdata (data_rdata),
    .data_ack   (data_ack),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_mask   (mem_mask),
    .mem_wr_en  (mem_wr_en),
    .mem_req    (mem_req),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .bus_owner  (bus_owner)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change 1ns after the edge, checks happen 2ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  logic [1:0] grants[$];
  logic [1:0] exp_order[10];

  initial begin
    rst = 1'b1;
    instr_addr = '0; instr_req = 1'b0;
    data_addr = '0; data_wdata = '0; data_mask = '0; data_wr_en = 1'b0; data_req = 1'b0;
    mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    settle();
    check("rst_mem_req",   32'(mem_req),   32'd0);
    check("rst_owner",     32'(bus_owner), 32'd0);
    check("rst_mem_addr",  mem_addr,       32'd0);
    check("rst_mem_wdata", mem_wdata,      32'd0);
    check("rst_mem_mask",  32'(mem_mask),  32'd0);
    check("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_acks",      32'({instr_ack, data_ack}), 32'd0);
    tick();
    rst = 1'b0;

    // Single fetch, zero-wait memory.
    instr_req = 1'b1; instr_addr = 32'h100;
    settle();
    check("t1_idle_req", 32'(mem_req), 32'd0);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    settle();
    check("t1_mem_req",   32'(mem_req),   32'd1);
    check("t1_mem_addr",  mem_addr,       32'h100);
    check("t1_wr_en",     32'(mem_wr_en), 32'd0);
    check("t1_mask",      32'(mem_mask),  32'hF);
    check("t1_owner",     32'(bus_owner), 32'd1);
    check("t1_instr_ack", 32'(instr_ack), 32'd1);
    check("t1_data_ack",  32'(data_ack),  32'd0);
    check("t1_instr_data", instr_data,    32'hCAFE_F00D);
    tick();
    instr_req = 1'b0; mem_ack = 1'b0;
    settle();
    check("t1_back_idle", 32'(bus_owner), 32'd0);
    check("t1_idle_mreq", 32'(mem_req),   32'd0);
    tick();

    // Simultaneous requests: data first, then fetch.
    instr_req = 1'b1; instr_addr = 32'h300;
    data_req = 1'b1; data_addr = 32'h2000; data_wdata = 32'hDEAD_BEEF;
    data_mask = 4'b0011; data_wr_en = 1'b1;
    tick();
    mem_ack = 1'b1;
    settle();
    check("t2_owner_d",  32'(bus_owner), 32'd2);
    check("t2_addr",     mem_addr,       32'h2000);
    check("t2_wdata",    mem_wdata,      32'hDEAD_BEEF);
    check("t2_mask",     32'(mem_mask),  32'h3);
    check("t2_wr_en",    32'(mem_wr_en), 32'd1);
    check("t2_data_ack", 32'(data_ack),  32'd1);
    check("t2_instr_ack", 32'(instr_ack), 32'd0);
    tick();
    data_req = 1'b0; mem_ack = 1'b0;
    settle();
    check("t2_gap_idle", 32'(bus_owner), 32'd0);
    tick();
    mem_ack = 1'b1;
    settle();
    check("t2_owner_i", 32'(bus_owner), 32'd1);
    check("t2_i_addr",  mem_addr,       32'h300);
    check("t2_i_wdata", mem_wdata,      32'd0);
    check("t2_i_mask",  32'(mem_mask),  32'hF);
    check("t2_i_wr_en", 32'(mem_wr_en), 32'd0);
    tick();
    instr_req = 1'b0; mem_ack = 1'b0; data_wr_en = 1'b0;
    tick();

    // Starvation limit with both requesters held and zero-wait memory.
    exp_order = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    data_req = 1'b1; instr_req = 1'b1; mem_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      settle();
      if (bus_owner != 2'd0) grants.push_back(bus_owner);
      tick();
    end
    data_req = 1'b0; instr_req = 1'b0; mem_ack = 1'b0;
    check("t3_grant_cnt", 32'(grants.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t3_grant%0d", i),
            (i < grants.size()) ? 32'(grants[i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));
    end
    tick();

    // Withdrawn fetch while memory stalls.
    instr_req = 1'b1; instr_addr = 32'h444;
    tick();
    instr_req = 1'b0; instr_addr = 32'h888;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("t4_stall_req%0d", i),  32'(mem_req),   32'd1);
      check($sformatf("t4_stall_addr%0d", i), mem_addr,       32'h444);
      tick();
    end
    mem_ack = 1'b1;
    settle();
    check("t4_ack_dropped", 32'(instr_ack), 32'd0);
    check("t4_owner",       32'(bus_owner), 32'd1);
    tick();
    mem_ack = 1'b0;
    settle();
    check("t4_idle", 32'(bus_owner), 32'd0);
    tick();

    // Address change after grant.
    data_req = 1'b1; data_addr = 32'h40; data_wr_en = 1'b0;
    tick();
    data_addr = 32'h80;
    for (int i = 0; i < 2; i++) begin
      settle();
      check($sformatf("t5_addr%0d", i), mem_addr, 32'h40);
      tick();
    end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    settle();
    check("t5_addr_ack",  mem_addr,          32'h40);
    check("t5_data_ack",  32'(data_ack),     32'd1);
    check("t5_rdata",     data_rdata,        32'h1234_5678);
    tick();
    data_req = 1'b0; mem_ack = 1'b0;
    settle();
    check("t5_idle", 32'(bus_owner), 32'd0);
    tick();

    // Reset in the middle of a data access.
    data_req = 1'b1; data_addr = 32'h500; data_wr_en = 1'b1; data_wdata = 32'h55;
    tick();
    settle();
    check("t6_owner_d", 32'(bus_owner), 32'd2);
    rst = 1'b1;
    tick();
    data_req = 1'b0; mem_ack = 1'b1;
    settle();
    check("t6_owner",   32'(bus_owner), 32'd0);
    check("t6_mem_req", 32'(mem_req),   32'd0);
    check("t6_acks",    32'({instr_ack, data_ack}), 32'd0);
    check("t6_addr",    mem_addr,       32'd0);
    rst = 1'b0;
    tick();
    settle();
    check("t6_spurious_owner", 32'(bus_owner), 32'd0);
    check("t6_spurious_acks",  32'({instr_ack, data_ack}), 32'd0);
    mem_ack = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
